// File: rtl/cover_pkg.sv
// Shared definitions for the toggle-cover collectors and the coverage aggregator.
package cover_pkg;

  localparam int unsigned COVER_TOTAL_DEFAULT = 10906;

  function automatic int unsigned cover_idx_w(input int unsigned total);
    return (total <= 1) ? 1 : $clog2(total);
  endfunction

  typedef logic [cover_idx_w(COVER_TOTAL_DEFAULT)-1:0] cover_idx_t;

  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] n;
    n = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      n = n + 7'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/cover_lsb_pick.sv
// Combinational lowest-set-bit finder: flag, binary index and one-hot of the lowest set bit.
module cover_lsb_pick #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic             any_o,
  output logic [IDXW-1:0]  idx_o,
  output logic [WIDTH-1:0] onehot_o
);

  always_comb begin
    any_o    = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (vec_i[i] && !any_o) begin
        any_o       = 1'b1;
        idx_o       = IDXW'(i);
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cover_toggle_collector.sv
// Captures a toggle-hit vector into a pending bitmap and drains it as cover-point indices,
// one per valid/ready handshake, with optional report-once dedup and a merge counter.
module cover_toggle_collector
  import cover_pkg::*;
#(
  parameter  int unsigned WIDTH       = 7,
  parameter  int unsigned COVER_INDEX = 0,
  parameter  int unsigned COVER_TOTAL = COVER_TOTAL_DEFAULT,
  parameter  int unsigned DEDUP       = 1,
  parameter  int unsigned CNT_W       = 16,
  localparam int unsigned IW          = cover_idx_w(COVER_TOTAL),
  localparam int unsigned CW          = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] valid,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IW-1:0]    out_index,
  output logic [WIDTH-1:0] hit_map,
  output logic [CW-1:0]    hit_count,
  output logic [CNT_W-1:0] merge_cnt,
  output logic             busy
);

  localparam int unsigned PW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned SUM_W = CNT_W + 8;

  if (WIDTH < 1 || WIDTH > 64 || COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_param_check
    $error("cover_toggle_collector: WIDTH must be 1..64 and COVER_INDEX+WIDTH <= COVER_TOTAL");
  end

  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] hit_map_q, hit_map_d;
  logic [CW-1:0]    hit_count_q, hit_count_d;
  logic [CNT_W-1:0] merge_cnt_q, merge_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [IW-1:0]    out_index_q, out_index_d;

  logic             pick_any;
  logic [PW-1:0]    pick_idx;
  logic [WIDTH-1:0] pick_onehot;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] seen;
  logic             load;
  logic [WIDTH-1:0] load_mask;
  logic [WIDTH-1:0] merge_bits;
  logic [SUM_W-1:0] merge_sum;

  cover_lsb_pick #(
    .WIDTH (WIDTH),
    .IDXW  (PW)
  ) u_pick (
    .vec_i    (pending_q),
    .any_o    (pick_any),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot)
  );

  always_comb begin
    acc  = '0;
    seen = '0;
    if (enable) begin
      seen = valid;
      acc  = (DEDUP != 0) ? (valid & ~hit_map_q) : valid;
    end

    load      = !out_valid_q || out_ready;
    load_mask = load ? pick_onehot : '0;

    merge_bits = acc & pending_q & ~load_mask;
    merge_sum  = SUM_W'(merge_cnt_q) + SUM_W'(popcount64(64'(merge_bits)));

    pending_d = (pending_q & ~load_mask) | acc;

    // Sticky map records every enabled hit, so a hit coinciding with clear survives it even
    // when dedup suppresses its report (acc is masked by the pre-clear map).
    hit_map_d   = (clear ? '0 : hit_map_q) | seen;
    hit_count_d = CW'(popcount64(64'(hit_map_d)));

    if (clear) begin
      merge_cnt_d = '0;
    end else if (merge_sum > SUM_W'({CNT_W{1'b1}})) begin
      merge_cnt_d = '1;
    end else begin
      merge_cnt_d = merge_sum[CNT_W-1:0];
    end

    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    if (load) begin
      out_valid_d = pick_any;
      if (pick_any) begin
        out_index_d = IW'(COVER_INDEX) + IW'(pick_idx);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_q   <= '0;
      hit_map_q   <= '0;
      hit_count_q <= '0;
      merge_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
    end else begin
      pending_q   <= pending_d;
      hit_map_q   <= hit_map_d;
      hit_count_q <= hit_count_d;
      merge_cnt_q <= merge_cnt_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign hit_map   = hit_map_q;
  assign hit_count = hit_count_q;
  assign merge_cnt = merge_cnt_q;
  assign busy      = (pending_q != '0) || out_valid_q;

endmodule
